// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Request/response ALU; single-cycle logic/arith/shift ops and
//               an iterative shift-add unsigned multiply into HI/LO.
// Revision    : 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [5:0] c_AND   = 6'd36;
    localparam logic [5:0] c_OR    = 6'd37;
    localparam logic [5:0] c_ADD   = 6'd32;
    localparam logic [5:0] c_SUB   = 6'd34;
    localparam logic [5:0] c_SLT   = 6'd42;
    localparam logic [5:0] c_SLTU  = 6'd43;
    localparam logic [5:0] c_SLL   = 6'd0;
    localparam logic [5:0] c_SRL   = 6'd2;
    localparam logic [5:0] c_MULTU = 6'd25;
    localparam logic [5:0] c_MFHI  = 6'd16;
    localparam logic [5:0] c_MFLO  = 6'd18;
    localparam logic [SHW-1:0] c_LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_ovf;
    logic               w_ill;
    logic [2*WIDTH-1:0] w_prod_next;

    assign in_ready    = (r_state == S_IDLE);
    assign w_sum       = dataA + dataB;
    assign w_diff      = dataA + ~dataB + WIDTH'(1);
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        case (Signal)
            c_AND:  w_result = dataA & dataB;
            c_OR:   w_result = dataA | dataB;
            c_ADD: begin
                w_result = w_sum;
                w_ovf    = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != dataA[WIDTH-1]);
            end
            c_SUB: begin
                w_result = w_diff;
                w_ovf    = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != dataA[WIDTH-1]);
            end
            c_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            c_SLTU: w_result = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
            c_SLL:  w_result = dataA << dataB[SHW-1:0];
            c_SRL:  w_result = dataA >> dataB[SHW-1:0];
            c_MFHI: w_result = r_hi;
            c_MFLO: w_result = r_lo;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            out_valid <= 1'b0;
            dataOut   <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (Signal == c_MULTU) begin
                            r_state  <= S_MUL;
                            r_cnt    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, dataA};
                            r_mplier <= dataB;
                            r_prod   <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            dataOut   <= w_result;
                            zero      <= (w_result == '0);
                            overflow  <= w_ovf;
                            illegal   <= w_ill;
                        end
                    end
                end
                S_MUL: begin
                    // Multiplicand shifts left as multiplier shifts right,
                    // so bit i of the multiplier always meets multiplicand<<i.
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == c_LAST_ITER) begin
                        r_state   <= S_IDLE;
                        r_hi      <= w_prod_next[2*WIDTH-1:WIDTH];
                        r_lo      <= w_prod_next[WIDTH-1:0];
                        out_valid <= 1'b1;
                        dataOut   <= w_prod_next[WIDTH-1:0];
                        zero      <= (w_prod_next[WIDTH-1:0] == '0);
                        overflow  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Vector table plus scoreboard bench for alu_seq (WIDTH=32).
// Revision    : 1.0
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [5:0]       Signal = 6'd0;
    logic [WIDTH-1:0] dataA = '0;
    logic [WIDTH-1:0] dataB = '0;
    logic             out_valid;
    logic [WIDTH-1:0] dataOut;
    logic             zero;
    logic             overflow;
    logic             illegal;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Signal   (Signal),
        .dataA    (dataA),
        .dataB    (dataB),
        .out_valid(out_valid),
        .dataOut  (dataOut),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]       sig;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] out;
        logic             z;
        logic             ov;
        logic             il;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             z;
        logic             ov;
        logic             il;
        int               cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one request, hold it until accepted, queue its expected response.
    task automatic send(input logic [5:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eo, input logic ez, input logic eov, input logic eil,
                        input int lat, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        Signal   = s;
        dataA    = a;
        dataB    = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %0b expected 1", in_ready);
        end else begin
            e.out = eo; e.z = ez; e.ov = eov; e.il = eil; e.cyc = acc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Response monitor: every out_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 dataOut=%0h expected no response", dataOut);
                end else begin
                    e = sb.pop_front();
                    if (dataOut !== e.out || zero !== e.z || overflow !== e.ov ||
                        illegal !== e.il || cyc !== e.cyc) begin
                        bad++;
                        $display("FAIL response: got out=%0h z=%0b ov=%0b il=%0b cyc=%0d expected out=%0h z=%0b ov=%0b il=%0b cyc=%0d",
                                 dataOut, zero, overflow, illegal, cyc, e.out, e.z, e.ov, e.il, e.cyc);
                    end
                end
            end else if (illegal) begin
                total++;
                bad++;
                $display("FAIL illegal_without_valid: got illegal=1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[17];
    int   acc, acc_mul;

    initial begin
        vecs[0]  = '{6'd32, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{6'd34, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'd42, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'd43, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6'd2,  32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'd37, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'd32, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'd34, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{6'd34, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{6'd0,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'd0,  32'h00000003, 32'h00000020, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'd42, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{6'd43, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'd16, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{6'd63, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{6'd32, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

        // Reset values while reset is held
        #1;
        chk("rst_dataOut",   64'(dataOut),   64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_zero",      64'(zero),      64'h0);
        chk("rst_overflow",  64'(overflow),  64'h0);
        chk("rst_illegal",   64'(illegal),   64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // Table vectors issued back-to-back
        for (int i = 0; i < 17; i++)
            send(vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].z, vecs[i].ov, vecs[i].il, 0, acc);

        // MULTU max*max, in_ready low for WIDTH cycles, then HI/LO reads
        send(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, WIDTH, acc_mul);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk($sformatf("mul_busy_%0d", i), 64'(in_ready), 64'h0);
        end
        send(6'd16, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0, acc);
        chk("mul_next_accept", 64'(acc), 64'(acc_mul + WIDTH + 1));
        send(6'd18, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b0, 1'b0, 0, acc);

        // MULTU with zero low half, then a request held during the multiply
        send(6'd25, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b0, WIDTH, acc_mul);
        send(6'd32, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 0, acc);
        chk("held_accept_cycle", 64'(acc), 64'(acc_mul + WIDTH + 1));
        send(6'd16, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b0, 1'b0, 0, acc);

        // Reset in the middle of a multiply aborts it and clears HI/LO
        send(6'd25, 32'h00000003, 32'h00000007, 32'h00000015, 1'b0, 1'b0, 1'b0, WIDTH, acc_mul);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_dataOut",   64'(dataOut),   64'h0);
        chk("abort_out_valid", 64'(out_valid), 64'h0);
        chk("abort_zero",      64'(zero),      64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'h1);
        send(6'd16, 32'h0, 32'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 0, acc);
        send(6'd18, 32'h0, 32'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 0, acc);
        repeat (WIDTH + 5) @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
